// File: rtl/flash_dma_sched.sv
// flash_dma_sched: claims the shared SPI master from the CPU, issues a flash
// READ (0x03 + 24-bit address) and streams len bytes into SRAM.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   start, flash_addr,
//   mem_base, len               - transfer request and its parameters
//   busy, done                  - transfer in progress / completion pulse
//   cpu_flash_cs_n, cpu_sd_cs_n,
//   cpu_spi_req, cpu_wait_n     - CPU side of the bus arbitration
//   dma_own, dma_flash_cs_n     - parent mux select and flash CS
//   spi_start, spi_tx,
//   spi_busy, spi_rx            - SPI master byte interface
//   mem_addr, mem_data,
//   mem_we, mem_wait            - SRAM write port
module flash_dma_sched #(
    parameter int MEMAW = 21,
    parameter int LENW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [23:0]      flash_addr,
    input  logic [MEMAW-1:0] mem_base,
    input  logic [LENW-1:0]  len,
    output logic             busy,
    output logic             done,
    input  logic             cpu_flash_cs_n,
    input  logic             cpu_sd_cs_n,
    input  logic             cpu_spi_req,
    output logic             cpu_wait_n,
    output logic             dma_own,
    output logic             dma_flash_cs_n,
    output logic             spi_start,
    output logic [7:0]       spi_tx,
    input  logic             spi_busy,
    input  logic [7:0]       spi_rx,
    output logic [MEMAW-1:0] mem_addr,
    output logic [7:0]       mem_data,
    output logic             mem_we,
    input  logic             mem_wait
);

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_CSLO, S_CMD, S_A2, S_A1,
        S_A0, S_RD, S_WR, S_CSHI, S_FIN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [23:0]      addr_q;
    logic [MEMAW-1:0] base_q;
    logic [MEMAW-1:0] idx_q;
    logic [LENW-1:0]  rem_q;
    logic [7:0]       data_q;
    logic             sent_q;
    logic             byte_st;
    logic             byte_end;
    logic             bus_free;

    // sent_q marks that this byte state already issued its spi_start;
    // the byte is over once the master is seen idle afterwards.
    assign byte_st  = (state == S_CMD) || (state == S_A2) ||
                      (state == S_A1)  || (state == S_A0) ||
                      (state == S_RD);
    assign byte_end = sent_q & ~spi_busy;
    assign bus_free = cpu_flash_cs_n & cpu_sd_cs_n &
                      ~cpu_spi_req & ~spi_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        spi_tx   = 8'hFF;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (len == '0) ? S_FIN : S_ARB;
                end
            end
            S_ARB: begin
                if (bus_free) begin
                    state_nx = S_CSLO;
                end
            end
            S_CSLO: state_nx = S_CMD;
            S_CMD: begin
                spi_tx = 8'h03;
                if (byte_end) state_nx = S_A2;
            end
            S_A2: begin
                spi_tx = addr_q[23:16];
                if (byte_end) state_nx = S_A1;
            end
            S_A1: begin
                spi_tx = addr_q[15:8];
                if (byte_end) state_nx = S_A0;
            end
            S_A0: begin
                spi_tx = addr_q[7:0];
                if (byte_end) state_nx = S_RD;
            end
            S_RD: begin
                if (byte_end) state_nx = S_WR;
            end
            S_WR: begin
                if (!mem_wait) begin
                    state_nx = (rem_q == LENW'(1)) ? S_CSHI : S_RD;
                end
            end
            S_CSHI: state_nx = S_FIN;
            S_FIN:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            base_q <= '0;
            idx_q  <= '0;
            rem_q  <= '0;
            data_q <= '0;
            sent_q <= 1'b0;
        end else begin
            sent_q <= (state_nx != state) ? 1'b0 : (sent_q | spi_start);
            if (state == S_IDLE && start && len != '0) begin
                addr_q <= flash_addr;
                base_q <= mem_base;
                idx_q  <= '0;
                rem_q  <= len;
            end
            if (state == S_RD && byte_end) begin
                data_q <= spi_rx;
            end
            if (state == S_WR && !mem_wait) begin
                idx_q <= idx_q + MEMAW'(1);
                rem_q <= rem_q - LENW'(1);
            end
        end
    end

    assign spi_start      = byte_st & ~sent_q;
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_FIN);
    assign dma_own        = busy && (state != S_ARB) && (state != S_FIN);
    assign dma_flash_cs_n = ~(dma_own && (state != S_CSHI));
    assign cpu_wait_n     = ~(dma_own & cpu_spi_req);
    assign mem_we         = (state == S_WR);
    assign mem_addr       = base_q + idx_q;
    assign mem_data       = data_q;

endmodule

// File: tb/tb_flash_dma_sched.sv
// Bench for flash_dma_sched: SPI master and SRAM models with scoreboards,
// a table of transfers and hand-written arbitration/stall/reset sequences.
module tb_flash_dma_sched;

    localparam int S = 3;

    typedef struct {
        logic [23:0] fa;
        logic [20:0] base;
        logic [15:0] ln;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] flash_addr = '0;
    logic [20:0] mem_base = '0;
    logic [15:0] len = '0;
    logic        busy;
    logic        done;
    logic        cpu_flash_cs_n = 1'b1;
    logic        cpu_sd_cs_n = 1'b1;
    logic        cpu_spi_req = 1'b0;
    logic        cpu_wait_n;
    logic        dma_own;
    logic        dma_flash_cs_n;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic        spi_busy = 1'b0;
    logic [7:0]  spi_rx = '0;
    logic [20:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        mem_wait = 1'b0;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [28:0] wr_q[$];
    int          wr_idx = 0;
    int          stall_idx = -1;
    int          stall_left = 0;
    logic        held_chk = 1'b0;
    int          spi_cnt = 0;
    vec_t        vt[5];

    flash_dma_sched dut (
        .clk(clk), .rst(rst), .start(start),
        .flash_addr(flash_addr), .mem_base(mem_base), .len(len),
        .busy(busy), .done(done),
        .cpu_flash_cs_n(cpu_flash_cs_n), .cpu_sd_cs_n(cpu_sd_cs_n),
        .cpu_spi_req(cpu_spi_req), .cpu_wait_n(cpu_wait_n),
        .dma_own(dma_own), .dma_flash_cs_n(dma_flash_cs_n),
        .spi_start(spi_start), .spi_tx(spi_tx),
        .spi_busy(spi_busy), .spi_rx(spi_rx),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .mem_wait(mem_wait)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // SPI master model: busy the cycle after spi_start, low S clocks later
    always begin
        logic st;
        @(negedge clk);
        st = spi_start;
        if (st) begin
            chk("spi_idle_at_start", 32'(spi_busy), 32'd0);
            chk("cs_low_at_start", 32'(dma_flash_cs_n), 32'd0);
            chk("own_at_start", 32'(dma_own), 32'd1);
            if (tx_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spi_tx: unexpected byte %02h", spi_tx);
            end else begin
                chk("spi_tx", 32'(spi_tx), 32'(tx_q.pop_front()));
            end
        end
        @(posedge clk);
        if (st) begin
            spi_busy <= 1'b1;
            spi_cnt  <= S - 1;
        end else if (spi_cnt != 0) begin
            spi_cnt <= spi_cnt - 1;
            if (spi_cnt == 1) begin
                spi_busy <= 1'b0;
                if (rx_q.size() != 0) spi_rx <= rx_q.pop_front();
                else spi_rx <= 8'hEE;
            end
        end
    end

    // SRAM model with an optional stall on one write
    always @(negedge clk) begin
        logic [28:0] w;
        if (held_chk) begin
            chk("we_held", 32'(mem_we), 32'd1);
            held_chk = 1'b0;
        end
        if (mem_we && wr_idx == stall_idx && stall_left > 0) begin
            mem_wait = 1'b1;
            stall_left--;
            held_chk = 1'b1;
            if (wr_q.size() != 0) begin
                chk("stall_addr", 32'(mem_addr), 32'(wr_q[0][28:8]));
                chk("stall_data", 32'(mem_data), 32'(wr_q[0][7:0]));
            end
        end else begin
            mem_wait = 1'b0;
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mem_write: unexpected %0h=%02h",
                             mem_addr, mem_data);
                end else begin
                    w = wr_q.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(w[28:8]));
                    chk("mem_data", 32'(mem_data), 32'(w[7:0]));
                end
                wr_idx++;
            end
        end
    end

    task automatic run_xfer(input logic [23:0] fa, input logic [20:0] base,
                            input logic [15:0] ln, input int exp_lat,
                            input int arb_hold, input int req_at,
                            input logic fixed);
        logic [7:0]  d;
        logic [20:0] a;
        int          cyc;
        logic        got;
        logic        saw_st;
        logic        saw_own;
        if (ln != 0) begin
            tx_q.push_back(8'h03);
            tx_q.push_back(fa[23:16]);
            tx_q.push_back(fa[15:8]);
            tx_q.push_back(fa[7:0]);
            repeat (4) rx_q.push_back(8'hEE);
            for (int j = 0; j < int'(ln); j++) begin
                d = fixed ? 8'(8'h11 * (j + 1)) : 8'($urandom);
                a = base + 21'(j);
                rx_q.push_back(d);
                tx_q.push_back(8'hFF);
                wr_q.push_back({a, d});
            end
        end
        wr_idx = 0;
        @(negedge clk);
        flash_addr = fa;
        mem_base = base;
        len = ln;
        start = 1'b1;
        if (arb_hold > 0) cpu_flash_cs_n = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        got = 1'b0;
        saw_st = 1'b0;
        saw_own = 1'b0;
        while (!got && cyc < 2000) begin
            if (arb_hold > 0 && cyc == arb_hold) cpu_flash_cs_n = 1'b1;
            if (req_at > 0 && cyc == req_at) cpu_spi_req = 1'b1;
            #1;
            if (cyc < arb_hold) begin
                chk("arb_own", 32'(dma_own), 32'd0);
                chk("arb_spi_start", 32'(spi_start), 32'd0);
            end
            if (req_at > 0 && cyc >= req_at)
                chk("cpu_wait_n", 32'(cpu_wait_n), done ? 32'd1 : 32'd0);
            chk("busy", 32'(busy), 32'd1);
            if (spi_start) saw_st = 1'b1;
            if (dma_own) saw_own = 1'b1;
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: no done after %0d cycles", cyc);
        end else begin
            chk("latency", 32'(cyc), 32'(exp_lat));
        end
        cpu_spi_req = 1'b0;
        @(negedge clk);
        #1;
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_own", 32'(dma_own), 32'd0);
        chk("idle_cs", 32'(dma_flash_cs_n), 32'd1);
        if (ln == 0) begin
            chk("len0_spi_start", 32'(saw_st), 32'd0);
            chk("len0_own", 32'(saw_own), 32'd0);
        end
        chk("tx_left", 32'(tx_q.size()), 32'd0);
        chk("wr_left", 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        int k;
        int nst;
        vt[0] = '{24'h0A1B2C, 21'h01000, 16'd3, 35};
        vt[1] = '{24'h000000, 21'h00000, 16'd0, 1};
        vt[2] = '{24'hFFFFFF, 21'h00ABC, 16'd1, 25};
        vt[3] = '{24'h123456, 21'h1FFFFF, 16'd2, 30};
        vt[4] = '{24'h800001, 21'h05555, 16'd5, 45};

        cpu_spi_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_own", 32'(dma_own), 32'd0);
        chk("rst_cs", 32'(dma_flash_cs_n), 32'd1);
        chk("rst_wait_n", 32'(cpu_wait_n), 32'd1);
        chk("rst_spi_start", 32'(spi_start), 32'd0);
        chk("rst_spi_tx", 32'(spi_tx), 32'hFF);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        cpu_spi_req = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_xfer(vt[i].fa, vt[i].base, vt[i].ln, vt[i].lat,
                     0, 0, (i == 0));

        // CPU holds flash CS low for 20 cycles after the start
        run_xfer(24'h0A1B2C, 21'h01000, 16'd3, 54, 20, 0, 1'b1);

        // CPU touches the SPI data port mid-transfer
        run_xfer(24'h445566, 21'h00200, 16'd2, 30, 0, 10, 1'b0);

        // address wrap with a 3-cycle stall on the second write
        stall_idx = 1;
        stall_left = 3;
        run_xfer(24'h000100, 21'h1FFFFE, 16'd4, 43, 0, 0, 1'b0);
        chk("stall_used", 32'(stall_left), 32'd0);
        stall_idx = -1;

        // reset while the A1 address byte is being sent
        tx_q.push_back(8'h03);
        tx_q.push_back(8'h5A);
        tx_q.push_back(8'hA5);
        repeat (3) rx_q.push_back(8'hEE);
        @(negedge clk);
        flash_addr = 24'h5AA5C3;
        mem_base = 21'h00300;
        len = 16'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        nst = 0;
        while (nst < 3 && k < 200) begin
            if (spi_start) nst++;
            if (nst < 3) begin
                @(negedge clk);
                k++;
            end
        end
        if (nst < 3) begin
            n_vec++;
            n_err++;
            $display("FAIL a1_timeout: saw %0d spi_start pulses", nst);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_own", 32'(dma_own), 32'd0);
        chk("abort_cs", 32'(dma_flash_cs_n), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_tx_left", 32'(tx_q.size()), 32'd0);
        chk("abort_wr_left", 32'(wr_q.size()), 32'd0);
        rx_q.delete();
        run_xfer(24'hC0FFEE, 21'h00040, 16'd2, 30, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
